// File: rtl/seq_mult_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mult_param                                                |
// | Brief    : Serial-parallel multiplier, WIDTH-bit operands, DIGIT bits    |
// |            retired per cycle, runtime signed/unsigned, start/busy/done.  |
// |            Optional abort input enabled by macro SEQ_MULT_ABORT_EN.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SEQ_MULT_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   MP,
  input  logic [WIDTH-1:0]   MC,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mp_q, mp_d;
  logic                 sgn_q, sgn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic                 abort_req;
  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   corr;

`ifdef SEQ_MULT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign P    = p_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // The multiplicand is kept sign/zero-extended and pre-shifted so each cycle
  // only adds DIGIT shifted copies; the multiplier is treated as unsigned and
  // its negative MSB weight (signed mode) is removed on the final step.
  always_comb begin
    pp = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (mp_q[j]) begin
        pp = pp + (mc_q << j);
      end
    end
    corr = (sgn_q && mp_q[DIGIT-1]) ? (mc_q << DIGIT) : '0;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mp_d    = MP;
          mc_d    = {{WIDTH{signed_mode & MC[WIDTH-1]}}, MC};
          sgn_d   = signed_mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_q + pp;
          mp_d  = mp_q >> DIGIT;
          mc_d  = mc_q << DIGIT;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            p_d     = acc_q + pp - corr;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mult_param                                             |
// | Brief    : Scoreboard bench for seq_mult_param, DIGIT=1 and DIGIT=4 DUTs.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_seq_mult_param;

  typedef struct {
    logic [63:0] p;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st1 = 1'b0, st4 = 1'b0;
  logic        sm1 = 1'b0, sm4 = 1'b0;
  logic [31:0] mp1 = '0, mc1 = '0, mp4 = '0, mc4 = '0;
  logic [63:0] P1, P4;
  logic        busy1, busy4, done1, done4;
`ifdef SEQ_MULT_ABORT_EN
  logic        ab1 = 1'b0, ab4 = 1'b0;
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q1[$];
  exp_t q4[$];
  int   bcnt1 = 0, bcnt4 = 0;
  logic pd1 = 1'b0, pd4 = 1'b0;

  seq_mult_param #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(st1),
`ifdef SEQ_MULT_ABORT_EN
    .abort(ab1),
`endif
    .MP(mp1), .MC(mc1), .signed_mode(sm1),
    .P(P1), .busy(busy1), .done(done1)
  );

  seq_mult_param #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(st4),
`ifdef SEQ_MULT_ABORT_EN
    .abort(ab4),
`endif
    .MP(mp4), .MC(mc4), .signed_mode(sm4),
    .P(P4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a DUT pulses done.
  task automatic mon(input int id, input logic dn, input logic bs, input logic [63:0] p);
    exp_t e;
    int   n;
    int   bc;
    logic pd;
    n  = (id == 1) ? 32 : 8;
    bc = (id == 1) ? bcnt1 : bcnt4;
    pd = (id == 1) ? pd1 : pd4;
    if (dn === 1'b1) begin
      chk($sformatf("d%0d done_not_consecutive", id), {63'd0, pd}, 64'd0);
      if ((id == 1 && q1.size() == 0) || (id == 4 && q4.size() == 0)) begin
        tests++;
        fails++;
        $display("FAIL d%0d unexpected_done: got done at cycle %0d with P=%h, expected none", id, cyc, p);
      end else begin
        if (id == 1) e = q1.pop_front();
        else         e = q4.pop_front();
        chk($sformatf("d%0d product", id), p, e.p);
        chk($sformatf("d%0d done_cycle", id), 64'(cyc), 64'(e.c));
        chk($sformatf("d%0d busy_cycles", id), 64'(bc), 64'(n));
      end
    end
    if (bs === 1'b1) bc++;
    else             bc = 0;
    if (id == 1) begin bcnt1 = bc; pd1 = (dn === 1'b1); end
    else         begin bcnt4 = bc; pd4 = (dn === 1'b1); end
  endtask

  always @(negedge clk) begin
    mon(1, done1, busy1, P1);
    mon(4, done4, busy4, P4);
  end

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] e);
    int n;
    n = (id == 1) ? 32 : 8;
    @(negedge clk);
    if (id == 1) begin
      mp1 = a; mc1 = b; sm1 = s; st1 = 1'b1;
      q1.push_back('{e, cyc + 1 + n});
    end else begin
      mp4 = a; mc4 = b; sm4 = s; st4 = 1'b1;
      q4.push_back('{e, cyc + 1 + n});
    end
    @(negedge clk);
    // Scramble operands after acceptance; the result must not change.
    if (id == 1) begin st1 = 1'b0; mp1 = $urandom; mc1 = $urandom; sm1 = ~s; end
    else         begin st4 = 1'b0; mp4 = $urandom; mc4 = $urandom; sm4 = ~s; end
  endtask

  task automatic drain(input int id);
    int k;
    k = 0;
    while (((id == 1) ? q1.size() : q4.size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (((id == 1) ? q1.size() : q4.size()) != 0) begin
      tests++;
      fails++;
      $display("FAIL d%0d timeout: got no done within 200 cycles, expected done", id);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset P1", P1, 64'd0);
    chk("reset busy1", {63'd0, busy1}, 64'd0);
    chk("reset done1", {63'd0, done1}, 64'd0);
    chk("reset P4", P4, 64'd0);
    rst = 1'b0;

    issue(1, 32'd15, 32'd7, 1'b0, 64'd105);
    drain(1);
    repeat (3) @(negedge clk);
    chk("hold P1 105", P1, 64'd105);

    issue(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001); drain(1);
    issue(1, 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1);        drain(1);
    issue(1, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000); drain(1);
    issue(1, 32'd0, 32'h0000FFFF, 1'b0, 64'd0);                       drain(1);

    // DIGIT=4: mid-run start with new operands must be ignored
    issue(4, 32'd1000, 32'd1000, 1'b0, 64'd1000000);
    repeat (3) @(negedge clk);
    mp4 = 32'd5; mc4 = 32'd5; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    drain(4);
    chk("hold P4 1000000", P4, 64'd1000000);
    issue(4, 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1);        drain(4);
    issue(4, 32'd7, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFFF2);        drain(4);
    issue(4, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000); drain(4);

    // Back-to-back: start held high through the DONE cycle
    @(negedge clk);
    mp1 = 32'd6; mc1 = 32'd7; sm1 = 1'b0; st1 = 1'b1;
    q1.push_back('{64'd42, cyc + 33});
    q1.push_back('{64'd81, cyc + 66});
    @(negedge clk);
    mp1 = 32'd9; mc1 = 32'd9;
    repeat (33) @(negedge clk);
    st1 = 1'b0;
    drain(1);

    // Reset at cycle 10 of a run: no done for it, next op works
    issue(1, 32'd1234, 32'd5678, 1'b0, 64'd7006652);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrun rst P1", P1, 64'd0);
    chk("midrun rst busy1", {63'd0, busy1}, 64'd0);
    chk("midrun rst done1", {63'd0, done1}, 64'd0);
    repeat (40) @(negedge clk);
    issue(1, 32'd2, 32'd3, 1'b0, 64'd6); drain(1);

`ifdef SEQ_MULT_ABORT_EN
    issue(1, 32'd6, 32'd7, 1'b0, 64'd42); drain(1);
    @(negedge clk);
    mp1 = 32'd100; mc1 = 32'd100; sm1 = 1'b0; st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (4) @(negedge clk);
    ab1 = 1'b1;
    @(negedge clk);
    ab1 = 1'b0;
    chk("abort busy1", {63'd0, busy1}, 64'd0);
    chk("abort done1", {63'd0, done1}, 64'd0);
    chk("abort P1", P1, 64'd42);
    repeat (40) @(negedge clk);
    chk("abort P1 held", P1, 64'd42);
`endif

    chk("q1 empty", 64'(q1.size()), 64'd0);
    chk("q4 empty", 64'(q4.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
